centroid_measure: RTL and testbench



---
 rtl/centroid_measure_pkg.sv | 22 ++
 rtl/centroid_measure_if.sv | 27 ++
 rtl/centroid_measure_serial_divider.sv | 74 +++++++
 rtl/centroid_measure.sv | 166 ++++++++++++++++
 tb/tb_centroid_measure.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/centroid_measure_pkg.sv
// Shared types and default sizing for the centroid measurement block.
// Optional build macro: CENTROID_ROUND_EN (round-half-up centroid instead of truncation).
package centroid_pkg;

  localparam int DISP_WIDTH_DEF = 11;
  localparam int CNT_WIDTH_DEF  = 22;
  localparam int MIN_PIXELS_DEF = 16;

  // Sum registers must hold the largest coordinate times the largest hit count.
  function automatic int sumWidth(input int cntW, input int dispW);
    return cntW + dispW;
  endfunction

  localparam int SUM_W_DEF = sumWidth(CNT_WIDTH_DEF, DISP_WIDTH_DEF);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/centroid_measure_if.sv
// Pixel-in / measurement-out bundle between the classifier, the centroid
// block and the Kalman tracker. Master is the environment, slave is the block.
interface centroid_measure_if #(
  parameter int DISP_WIDTH = centroid_pkg::DISP_WIDTH_DEF
);
  logic                  pix_valid;
  logic                  pix_hit;
  logic [DISP_WIDTH-1:0] pix_x;
  logic [DISP_WIDTH-1:0] pix_y;
  logic                  frame_end;
  logic [DISP_WIDTH-1:0] z_x;
  logic [DISP_WIDTH-1:0] z_y;
  logic                  valid;
  logic                  busy;
  logic                  lost;
  logic                  overrun;

  modport master (
    output pix_valid, pix_hit, pix_x, pix_y, frame_end,
    input  z_x, z_y, valid, busy, lost, overrun
  );

  modport slave (
    input  pix_valid, pix_hit, pix_x, pix_y, frame_end,
    output z_x, z_y, valid, busy, lost, overrun
  );
endinterface

// File: rtl/centroid_measure_serial_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The start cycle already resolves the MSB, so done pulses WIDTH cycles
// after the cycle in which start is high. Only the low QUOT_WIDTH quotient
// bits are brought out.
module serial_divider
  import centroid_pkg::*;
#(
  parameter int WIDTH      = SUM_W_DEF,
  parameter int QUOT_WIDTH = WIDTH
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      dividend,
  input  logic [WIDTH-1:0]      divisor,
  output logic [QUOT_WIDTH-1:0] quotient,
  output logic                  done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [WIDTH-1:0] remIn, quoIn, divIn, rem_d, quo_d;
  logic [WIDTH:0]   trial;
  logic [CW-1:0]    count_q;
  logic             run_q, done_q;

  // One restoring step; on start the operands come straight from the inputs.
  always_comb begin
    remIn = start ? '0 : rem_q;
    quoIn = start ? dividend : quo_q;
    divIn = start ? divisor : div_q;
    trial = {remIn, quoIn[WIDTH-1]};
    if (trial >= {1'b0, divIn}) begin
      rem_d = WIDTH'(trial - {1'b0, divIn});
      quo_d = {quoIn[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quoIn[WIDTH-2:0], 1'b0};
    end
  end

  // Iteration sequencing: first step on start, WIDTH-1 more while running.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        div_q   <= divIn;
        count_q <= CW'(WIDTH - 1);
        run_q   <= 1'b1;
      end else if (run_q) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        count_q <= count_q - CW'(1);
        if (count_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q[QUOT_WIDTH-1:0];
  assign done     = done_q;

endmodule

// File: rtl/centroid_measure.sv
// Per-frame centroid of target pixels for the Kalman tracker.
// Accumulates hit count and coordinate sums, snapshots them on frame_end and
// divides in the background while the next frame accumulates.
// Optional build macro: CENTROID_ROUND_EN adds floor(cnt/2) to each sum
// before division (round half up); latency is the same either way.
module centroid_measure
  import centroid_pkg::*;
#(
  parameter int DISP_WIDTH = DISP_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
  input logic               clk,
  input logic               areset,
  centroid_measure_if.slave bus
);
  localparam int SUM_W = sumWidth(CNT_WIDTH, DISP_WIDTH);

  logic                  hit;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]      sumX_q, sumX_d, sumY_q, sumY_d;
  logic                  sat_q, sat_d;
  logic [SUM_W-1:0]      snapX_d, snapY_d;
  logic [SUM_W-1:0]      snapX_q, snapY_q, snapCnt_q;
  logic                  enough;
  state_t                state_q;
  logic                  startDiv_q, valid_q, busy_q, lost_q, overrun_q;
  logic [DISP_WIDTH-1:0] zX_q, zY_q, quoX, quoY;
  logic                  doneX, doneY;

  assign hit = bus.pix_valid & bus.pix_hit;

  // Running totals including this cycle's pixel; frozen once the counter saturates.
  always_comb begin
    cnt_d  = cnt_q;
    sumX_d = sumX_q;
    sumY_d = sumY_q;
    sat_d  = sat_q;
    if (hit && !sat_q) begin
      if (cnt_q == '1) begin
        sat_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_WIDTH'(1);
        sumX_d = sumX_q + SUM_W'(bus.pix_x);
        sumY_d = sumY_q + SUM_W'(bus.pix_y);
      end
    end
  end

  // Dividends handed to the dividers, optionally biased for round-half-up.
  always_comb begin
`ifdef CENTROID_ROUND_EN
    snapX_d = SUM_W'({1'b0, sumX_d} + (SUM_W + 1)'(cnt_d >> 1));
    snapY_d = SUM_W'({1'b0, sumY_d} + (SUM_W + 1)'(cnt_d >> 1));
`else
    snapX_d = sumX_d;
    snapY_d = sumY_d;
`endif
  end

  assign enough = !sat_d && (cnt_d >= CNT_WIDTH'(MIN_PIXELS));

  // Accumulators restart empty after every frame_end, whatever the FSM is doing.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q  <= '0;
      sumX_q <= '0;
      sumY_q <= '0;
      sat_q  <= 1'b0;
    end else if (bus.frame_end) begin
      cnt_q  <= '0;
      sumX_q <= '0;
      sumY_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sumX_q <= sumX_d;
      sumY_q <= sumY_d;
      sat_q  <= sat_d;
    end
  end

  // Frame FSM: accept or reject a closed frame, wait for division, publish result.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= ACCUM;
      snapX_q    <= '0;
      snapY_q    <= '0;
      snapCnt_q  <= '0;
      startDiv_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      lost_q     <= 1'b0;
      overrun_q  <= 1'b0;
      zX_q       <= '0;
      zY_q       <= '0;
    end else begin
      startDiv_q <= 1'b0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
      overrun_q  <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (bus.frame_end) begin
            if (enough) begin
              snapX_q    <= snapX_d;
              snapY_q    <= snapY_d;
              snapCnt_q  <= SUM_W'(cnt_d);
              startDiv_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= DIV;
            end else begin
              lost_q <= 1'b1;
            end
          end
        end
        DIV: begin
          if (bus.frame_end) overrun_q <= 1'b1;
          if (doneX && doneY) begin
            zX_q    <= quoX;
            zY_q    <= quoY;
            valid_q <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (bus.frame_end) overrun_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ACCUM;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ACCUM;
        end
      endcase
    end
  end

  serial_divider #(.WIDTH(SUM_W), .QUOT_WIDTH(DISP_WIDTH)) divX (
    .clk      (clk),
    .areset   (areset),
    .start    (startDiv_q),
    .dividend (snapX_q),
    .divisor  (snapCnt_q),
    .quotient (quoX),
    .done     (doneX)
  );

  serial_divider #(.WIDTH(SUM_W), .QUOT_WIDTH(DISP_WIDTH)) divY (
    .clk      (clk),
    .areset   (areset),
    .start    (startDiv_q),
    .dividend (snapY_q),
    .divisor  (snapCnt_q),
    .quotient (quoY),
    .done     (doneY)
  );

  assign bus.z_x     = zX_q;
  assign bus.z_y     = zY_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.lost    = lost_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_centroid_measure.sv
// Self-checking bench for centroid_measure: directed frames plus random frames,
// every output compared each cycle against a frame-level reference model.
// Honours CENTROID_ROUND_EN when the design is built with it.
module tb_centroid_measure;
  import centroid_pkg::*;

  localparam int DW   = DISP_WIDTH_DEF;
  localparam int CW   = CNT_WIDTH_DEF;
  localparam int MINP = MIN_PIXELS_DEF;
  localparam int LAT  = 2 + CW + DW;

  logic clk = 1'b0;
  logic areset = 1'b1;

  always #5 clk = ~clk;

  centroid_measure_if #(.DISP_WIDTH(DW)) bus ();

  centroid_measure #(.DISP_WIDTH(DW), .CNT_WIDTH(CW), .MIN_PIXELS(MINP)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  longint mCnt = 0, mSx = 0, mSy = 0;
  int validCycle = -1, lostCycle = -1, overrunCycle = -1;
  int busyFrom = -1, busyTo = -1;
  int curZx = 0, curZy = 0, pendZx = 0, pendZy = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    end
  endtask

  // Centroid from the frame totals, rounded the way the build asks for.
  function automatic int centroid(input longint s, input longint n);
`ifdef CENTROID_ROUND_EN
    return int'((s + n / 2) / n);
`else
    return int'(s / n);
`endif
  endfunction

  task automatic checkCycle();
    if (cyc == validCycle) begin
      curZx = pendZx;
      curZy = pendZy;
    end
    checkOutput("valid",   32'(bus.valid),   32'(cyc == validCycle));
    checkOutput("busy",    32'(bus.busy),    32'(cyc >= busyFrom && cyc <= busyTo));
    checkOutput("lost",    32'(bus.lost),    32'(cyc == lostCycle));
    checkOutput("overrun", 32'(bus.overrun), 32'(cyc == overrunCycle));
    checkOutput("z_x",     32'(bus.z_x),     32'(curZx));
    checkOutput("z_y",     32'(bus.z_y),     32'(curZy));
  endtask

  // One clock of stimulus: check this cycle's outputs, drive inputs, advance the model.
  task automatic applyStimulus(input logic rst, input logic pv, input logic ph,
                               input logic [DW-1:0] x, input logic [DW-1:0] y,
                               input logic fe);
    @(negedge clk);
    checkCycle();
    areset        = rst;
    bus.pix_valid = pv;
    bus.pix_hit   = ph;
    bus.pix_x     = x;
    bus.pix_y     = y;
    bus.frame_end = fe;
    if (rst) begin
      mCnt = 0; mSx = 0; mSy = 0;
      validCycle = -1; lostCycle = -1; overrunCycle = -1;
      busyFrom = -1; busyTo = -1;
      curZx = 0; curZy = 0;
    end else begin
      if (pv && ph) begin
        mCnt += 1;
        mSx  += longint'(x);
        mSy  += longint'(y);
      end
      if (fe) begin
        if (cyc >= busyFrom && cyc <= busyTo) begin
          overrunCycle = cyc + 1;
        end else if (mCnt >= MINP) begin
          busyFrom   = cyc + 1;
          busyTo     = cyc + LAT;
          validCycle = cyc + LAT;
          pendZx     = centroid(mSx, mCnt);
          pendZy     = centroid(mSy, mCnt);
        end else begin
          lostCycle = cyc + 1;
        end
        mCnt = 0; mSx = 0; mSy = 0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic hits(input int n, input int x, input int y);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, DW'(x), DW'(y), 1'b0);
  endtask

  task automatic frameEnd();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_hit   = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.frame_end = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(2);

    // Uniform frame: centroid equals the single position
    hits(16, 100, 50);
    frameEnd();
    idle(LAT + 3);

    // Two clusters: truncated 11, rounded 12
    hits(8, 10, 7);
    hits(8, 13, 7);
    frameEnd();
    idle(LAT + 3);

    // One hit short: lost, outputs hold
    hits(15, 300, 300);
    frameEnd();
    idle(5);

    // 16th hit arrives in the frame_end cycle and still counts
    hits(15, 20, 30);
    applyStimulus(1'b0, 1'b1, 1'b1, DW'(20), DW'(30), 1'b1);
    idle(LAT + 3);

    // Second frame_end while dividing: overrun, that frame discarded
    hits(16, 200, 100);
    frameEnd();
    hits(9, 1, 1);
    frameEnd();
    hits(16, 5, 5);
    idle(LAT);
    frameEnd();
    idle(LAT + 3);

    // Reset in the middle of a division
    hits(16, 400, 400);
    frameEnd();
    idle(19);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(LAT + 5);
    hits(16, 60, 70);
    frameEnd();
    idle(LAT + 3);

    // Unqualified hits are ignored; extreme coordinates
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b1, DW'(i), DW'(i), 1'b0);
    hits(16, 2047, 0);
    frameEnd();
    idle(LAT + 3);

    // Random frames with noise, variable gaps and occasional overruns
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(8, 40);
      for (int h = 0; h < n; h++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++)
          applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, DW'($urandom), DW'($urandom), 1'b0);
      end
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, DW'($urandom), DW'($urandom), 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 50)); g++)
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      DW'($urandom), DW'($urandom), 1'b0);
    end
    idle(LAT + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
